// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 line levels and the baud-count helper.
// The receiver uses them today; a future transmitter can import the same package.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE_LEVEL  = 1'b1;
    localparam logic FRAME_START_LEVEL = 1'b0;
    localparam logic FRAME_STOP_LEVEL  = 1'b1;

    // Whole core clocks per serial bit; the fractional part is dropped.
    function automatic int baud_clocks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: mid-bit sampling FSM feeding a one-byte holding register
// presented over a valid/ready handshake, with framing-error pulse and sticky overrun.
//
// state      | meaning
// IDLE       | line idle, waiting for a low level on rx
// START      | counting to the middle of the start bit to reject glitches
// DATA       | sampling payload bits mid-bit, LSB first
// STOP       | sampling the stop bit mid-bit
// WAIT_HIGH  | after a framing error, waiting for the line to return high
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int CLOCKS_PER_BIT = baud_clocks(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;

    logic sample_tick;
    logic byte_done;
    logic handshake;
    logic overrun_set;

    sync_2ff #(
        .RESET_VAL (LINE_IDLE_LEVEL)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (serial_in),
        .q     (rx)
    );

    assign sample_tick = (cnt == '0);
    assign byte_done   = (state == ST_STOP) && sample_tick && (rx == FRAME_STOP_LEVEL);
    assign handshake   = data_out_valid && data_out_ready;
    assign overrun_set = byte_done && data_out_valid && !data_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx == FRAME_START_LEVEL) begin
                        state <= ST_START;
                        cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (sample_tick) begin
                        if (rx != FRAME_START_LEVEL) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            cnt     <= CNT_FULL;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        shift <= {rx, shift[DATA_BITS-1:1]};
                        cnt   <= CNT_FULL;
                        if (bit_idx == BIT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample_tick) begin
                        if (rx == FRAME_STOP_LEVEL) begin
                            state <= ST_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) parks here; start detection resumes only from IDLE.
                    if (rx == LINE_IDLE_LEVEL) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A byte landing in the same cycle as a handshake replaces the consumed one seamlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (byte_done && (!data_out_valid || handshake)) begin
                data_out       <= shift;
                data_out_valid <= 1'b1;
            end else if (handshake) begin
                data_out_valid <= 1'b0;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver at 16 clocks per bit: directed scenarios plus random frames.
module tb_uart_receiver;

    localparam int CPB     = 16;
    localparam int LATENCY = CPB / 2 + 9 * CPB + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       framing_error;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int fe_cycles = 0;
    int fe_run    = 0;
    int fe_long   = 0;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    uart_receiver #(
        .CLOCK_FREQ (16),
        .BAUD_RATE  (1),
        .DATA_BITS  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new byte is presented when valid rises or stays high across a handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            fe_run     = 0;
        end else begin
            if (data_out_valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", data_out, $time);
                end else begin
                    chk("byte_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_valid = data_out_valid;
            prev_hs    = data_out_valid && data_out_ready;
            if (framing_error) begin
                fe_cycles++;
                fe_run++;
                if (fe_run > 1) fe_long++;
            end else begin
                fe_run = 0;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        serial_in = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            wait_clk(CPB);
        end
        serial_in = stop_bit;
        wait_clk(CPB);
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n = 0;
        while (!data_out_valid && n < max_cycles) begin
            wait_clk(1);
            n++;
        end
        chk(name, {31'd0, data_out_valid}, 32'd1);
    endtask

    task automatic pulse_ready();
        data_out_ready = 1'b1;
        wait_clk(1);
        data_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int fe_before;
        logic [7:0] b;

        #1;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
        chk("rst_fe", {31'd0, framing_error}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(10);

        // 0x55 with ready low, measuring start-edge-to-valid latency
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                @(posedge clk);
                #1;
                while (lat < 400) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    if (data_out_valid) break;
                end
            end
        join
        chk("latency_55", lat, LATENCY);
        chk("valid_55", {31'd0, data_out_valid}, 32'd1);
        chk("fe_55", fe_cycles, 0);
        chk("overrun_55", {31'd0, overrun}, 32'd0);
        pulse_ready();
        chk("valid_after_ready", {31'd0, data_out_valid}, 32'd0);
        chk("data_held_55", {24'd0, data_out}, 32'h55);

        // 5-clock glitch must be rejected
        wait_clk(10);
        serial_in = 1'b0;
        wait_clk(5);
        serial_in = 1'b1;
        wait_clk(200);
        chk("glitch_valid", {31'd0, data_out_valid}, 32'd0);
        chk("glitch_fe", fe_cycles, 0);

        // Bad stop bit, line held low, then a clean frame
        fe_before = fe_cycles;
        send_byte(8'hA3, 1'b0);
        wait_clk(40);
        chk("fe_pulse_count", fe_cycles - fe_before, 1);
        chk("fe_pulse_width", fe_long, 0);
        chk("fe_valid", {31'd0, data_out_valid}, 32'd0);
        serial_in = 1'b1;
        wait_clk(CPB);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        wait_valid("valid_0f", 50);
        chk("overrun_0f", {31'd0, overrun}, 32'd0);
        pulse_ready();

        // Overrun: second byte dropped while the first is unread
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("ovr_data", {24'd0, data_out}, 32'h11);
        chk("ovr_valid", {31'd0, data_out_valid}, 32'd1);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        pulse_ready();
        chk("ovr_valid_clear", {31'd0, data_out_valid}, 32'd0);
        chk("ovr_clear", {31'd0, overrun}, 32'd0);

        // Handshake in the exact cycle the next byte completes
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_byte(8'h22, 1'b1);
            begin
                @(posedge clk);
                #1;
                wait_clk(LATENCY - 1);
                data_out_ready = 1'b1;
                wait_clk(1);
                data_out_ready = 1'b0;
            end
        join
        chk("swap_data", {24'd0, data_out}, 32'h22);
        chk("swap_valid", {31'd0, data_out_valid}, 32'd1);
        chk("swap_overrun", {31'd0, overrun}, 32'd0);

        // Reset mid-frame with 0x22 still held
        fork
            send_byte(8'hFF, 1'b1);
            begin
                @(posedge clk);
                #1;
                wait_clk(CPB + 4 * CPB + CPB / 2);
                rst_n = 1'b0;
                #1;
                chk("midrst_data", {24'd0, data_out}, 32'd0);
                chk("midrst_valid", {31'd0, data_out_valid}, 32'd0);
                chk("midrst_fe", {31'd0, framing_error}, 32'd0);
                chk("midrst_overrun", {31'd0, overrun}, 32'd0);
                wait_clk(3);
                rst_n = 1'b1;
            end
        join
        wait_clk(20);
        chk("midrst_no_byte", {31'd0, data_out_valid}, 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_valid("valid_3c", 50);
        chk("data_3c", {24'd0, data_out}, 32'h3C);
        pulse_ready();

        // Random frames with random idle gaps and a randomly toggling consumer
        fe_before = fe_cycles;
        for (int k = 0; k < 12; k++) begin
            logic done;
            done = 1'b0;
            b = 8'($urandom_range(0, 255));
            wait_clk($urandom_range(0, 20));
            exp_q.push_back(b);
            fork
                begin
                    send_byte(b, 1'b1);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        data_out_ready = 1'($urandom_range(0, 1));
                        wait_clk(1);
                    end
                    data_out_ready = 1'b0;
                end
            join
            chk("rand_overrun", {31'd0, overrun}, 32'd0);
        end
        chk("rand_fe", fe_cycles - fe_before, 0);

        begin
            int n = 0;
            data_out_ready = 1'b1;
            while (data_out_valid && n < 20) begin
                wait_clk(1);
                n++;
            end
            data_out_ready = 1'b0;
        end
        wait_clk(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
